// File: rtl/pc_pkg.sv
// Shared constants, S2 state encoding and saturating-add helpers for the popcount accumulator.
// Pure package; no timing or flow control of its own.
package pc_pkg;

  localparam int CNT15_W    = 4;
  localparam int SUM_W_DEF  = 16;
  localparam int WCNT_W_DEF = 8;

  typedef enum logic {
    S2_ACCUM = 1'b0,
    S2_FULL  = 1'b1
  } s2_state_t;

  // a + b clamped to the all-ones value of a w-bit field (w <= 32)
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << w) - 33'd1;
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

  // true when a + b would exceed a w-bit field, i.e. sat_add clamped
  function automatic logic sat_hit(input logic [31:0] a, input logic [31:0] b,
                                   input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << w) - 33'd1;
    return (sum > max);
  endfunction

endpackage

// File: rtl/pc_sn_15_4.sv
// 15-input parallel counter: bits sorted by a compare-exchange network, thermometer edge encoded.
// Purely combinational, zero latency; no flow control.
module pc_sn_15_4
  import pc_pkg::*;
(
  input  logic [14:0]         bits,
  output logic [CNT15_W-1:0]  cnt
);

  logic [14:0] therm;
  logic [15:0] therm_ext;
  logic        hi;
  logic        lo;

  // Odd-even transposition network: 15 stages fully sort 15 single-bit lanes, ones toward bit 0
  always_comb begin
    therm = bits;
    hi    = 1'b0;
    lo    = 1'b0;
    for (int s = 0; s < 15; s++) begin
      for (int i = s % 2; i < 14; i += 2) begin
        hi           = therm[i] | therm[i+1];
        lo           = therm[i] & therm[i+1];
        therm[i]     = hi;
        therm[i+1]   = lo;
      end
    end
  end

  assign therm_ext = {1'b0, therm};

  // Exactly one 1->0 boundary exists in the sorted vector; its position is the count
  always_comb begin
    cnt = '0;
    for (int k = 1; k <= 15; k++) begin
      if (therm_ext[k-1] && !therm_ext[k]) begin
        cnt = cnt | CNT15_W'(k);
      end
    end
  end

endmodule

// File: rtl/pc_accum_15.sv
// Per-frame popcount accumulator: S1 counts a word, S2 accumulates; result 2 cycles after last word.
// in_ready falls only when a last word sits in S1 while an unconsumed result is held.
module pc_accum_15
  import pc_pkg::*;
#(
  parameter int SUM_W  = SUM_W_DEF,
  parameter int WCNT_W = WCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [14:0]       in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [WCNT_W-1:0] out_words,
  output logic              out_sat
);

  logic [CNT15_W-1:0] pc_cnt;
  logic               s1_valid;
  logic               s1_last;
  logic [CNT15_W-1:0] s1_cnt;

  logic [SUM_W-1:0]   acc;
  logic [WCNT_W-1:0]  words;
  logic               sat_q;

  logic [SUM_W-1:0]   sum_nxt;
  logic [WCNT_W-1:0]  words_nxt;
  logic               sat_new;

  logic               in_fire;
  logic               s2_accept;
  logic               last_accept;
  logic               out_fire;

  s2_state_t          state_q;
  s2_state_t          state_d;

  pc_sn_15_4 u_pc (
    .bits (in_data),
    .cnt  (pc_cnt)
  );

  // A last word may only leave S1 if the result register is free or being drained this cycle
  assign s2_accept   = s1_valid & ~(s1_last & out_valid & ~out_ready);
  assign in_ready    = ~s1_valid | s2_accept;
  assign in_fire     = in_valid & in_ready;
  assign last_accept = s2_accept & s1_last;
  assign out_fire    = out_valid & out_ready;
  assign out_valid   = (state_q == S2_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_cnt   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_last  <= in_last;
      s1_cnt   <= pc_cnt;
    end else if (s2_accept) begin
      s1_valid <= 1'b0;
    end
  end

  assign sum_nxt   = SUM_W'(sat_add(32'(acc), 32'(s1_cnt), SUM_W));
  assign words_nxt = WCNT_W'(sat_add(32'(words), 32'd1, WCNT_W));
  assign sat_new   = sat_hit(32'(acc), 32'(s1_cnt), SUM_W) |
                     sat_hit(32'(words), 32'd1, WCNT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S2_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S2_ACCUM: if (last_accept) state_d = S2_FULL;
      S2_FULL:  if (out_fire && !last_accept) state_d = S2_ACCUM;
      default:  state_d = S2_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      words     <= '0;
      sat_q     <= 1'b0;
      out_sum   <= '0;
      out_words <= '0;
      out_sat   <= 1'b0;
    end else if (s2_accept) begin
      if (s1_last) begin
        out_sum   <= sum_nxt;
        out_words <= words_nxt;
        out_sat   <= sat_q | sat_new;
        acc       <= '0;
        words     <= '0;
        sat_q     <= 1'b0;
      end else begin
        acc       <= sum_nxt;
        words     <= words_nxt;
        sat_q     <= sat_q | sat_new;
      end
    end
  end

endmodule

// File: tb/tb_pc_accum_15.sv
// Bench for pc_accum_15: directed scenarios plus a random stalled stream against a frame-level model.
module tb_pc_accum_15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready4;
  logic [14:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_valid4;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [3:0]  out_sum4;
  logic [7:0]  out_words;
  logic [7:0]  out_words4;
  logic        out_sat;
  logic        out_sat4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sum;
    int words;
    bit sat;
    int sum4;
    bit sat4;
  } exp_t;

  typedef struct {
    logic [14:0] d;
    logic        l;
  } word_t;

  always #5 clk = ~clk;

  pc_accum_15 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_words(out_words), .out_sat(out_sat)
  );

  pc_accum_15 #(.SUM_W(4), .WCNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready),
    .out_sum(out_sum4), .out_words(out_words4), .out_sat(out_sat4)
  );

  function automatic int ones(input logic [14:0] d);
    int n = 0;
    for (int i = 0; i < 15; i++) n += int'(d[i]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [14:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL rst_in_ready4 got %0b want 1", in_ready4); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    checks++; if (out_sum !== 16'd0 || out_words !== 8'd0 || out_sat !== 1'b0) begin
      errors++; $display("FAIL rst_outputs got sum=%0d words=%0d sat=%0b want 0 0 0", out_sum, out_words, out_sat);
    end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b want 1", in_ready); end
    tick();
  endtask

  task automatic test_frame3();
    out_ready = 1'b1;
    send(15'h7FFF, 1'b0);
    send(15'h0001, 1'b0);
    send(15'h0000, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL f3_early_valid got %0b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL f3_latency out_valid got %0b want 1", out_valid); end
    checks++; if (out_sum !== 16'd16 || out_words !== 8'd3 || out_sat !== 1'b0) begin
      errors++; $display("FAIL f3_result got sum=%0d words=%0d sat=%0b want 16 3 0", out_sum, out_words, out_sat);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL f3_drop got %0b want 0", out_valid); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(15'h5555, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_sum !== 16'd8 || out_words !== 8'd1) begin
      errors++; $display("FAIL single got v=%0b sum=%0d words=%0d want 1 8 1", out_valid, out_sum, out_words);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(15'h0003, 1'b1);
    in_valid = 1'b1; in_data = 15'h000F; in_last = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_rdy got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_sum !== 16'd2 || out_words !== 8'd1) begin
        errors++; $display("FAIL b2b_hold got v=%0b sum=%0d words=%0d want 1 2 1", out_valid, out_sum, out_words);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall in_ready got %0b want 0", in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_release in_ready got %0b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_sum !== 16'd4 || out_words !== 8'd1) begin
      errors++; $display("FAIL b2b_second got v=%0b sum=%0d words=%0d want 1 4 1", out_valid, out_sum, out_words);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_sat();
    out_ready = 1'b1;
    send(15'h7FFF, 1'b0);
    send(15'h7FFF, 1'b1);
    tick();
    checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 4'd15 || out_sat4 !== 1'b1) begin
      errors++; $display("FAIL sat4 got v=%0b sum=%0d sat=%0b want 1 15 1", out_valid4, out_sum4, out_sat4);
    end
    checks++; if (out_sum !== 16'd30 || out_sat !== 1'b0) begin
      errors++; $display("FAIL sat16 got sum=%0d sat=%0b want 30 0", out_sum, out_sat);
    end
    send(15'h0001, 1'b1);
    tick();
    checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 4'd1 || out_sat4 !== 1'b0) begin
      errors++; $display("FAIL sat4_clear got v=%0b sum=%0d sat=%0b want 1 1 0", out_valid4, out_sum4, out_sat4);
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b0;
    send(15'h0001, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_held got %0b want 1", out_valid); end
    send(15'h00FF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_sum !== 16'd0 || out_words !== 8'd0 || out_sat !== 1'b0) begin
      errors++; $display("FAIL rm_async got v=%0b sum=%0d words=%0d sat=%0b want 0 0 0 0", out_valid, out_sum, out_words, out_sat);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %0b want 1", in_ready); end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(15'h0007, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_sum !== 16'd3 || out_words !== 8'd1 || out_sat !== 1'b0) begin
      errors++; $display("FAIL rm_next got v=%0b sum=%0d words=%0d sat=%0b want 1 3 1 0", out_valid, out_sum, out_words, out_sat);
    end
    tick();
  endtask

  task automatic test_throughput();
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = 15'(i + 1); in_last = (i % 3 == 2);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tput_ready word %0d got %0b want 1", i, in_ready); end
      if (out_valid) seen++;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++; if (seen != 4) begin errors++; $display("FAIL tput_results got %0d want 4", seen); end
  endtask

  task automatic test_random();
    word_t wq[$];
    exp_t  eq[$];
    exp_t  e;
    int    total, n, len, idx, cycles;
    bit    hold_pend, in_acc;
    logic [15:0] h_sum;
    logic [7:0]  h_words;
    logic        h_sat;
    total = 0; n = 0;
    for (int f = 0; f < 700; f++) begin
      len = (f == 300) ? 300 : $urandom_range(1, 8);
      for (int w = 0; w < len; w++) begin
        word_t x;
        x.d = 15'($urandom);
        if ($urandom_range(0, 3) == 0) x.d = 15'h7FFF;
        x.l = (w == len - 1);
        wq.push_back(x);
        total += ones(x.d);
        n++;
        if (x.l) begin
          e.sum   = (total > 65535) ? 65535 : total;
          e.words = (n > 255) ? 255 : n;
          e.sat   = (total > 65535) || (n > 255);
          e.sum4  = (total > 15) ? 15 : total;
          e.sat4  = (total > 15) || (n > 255);
          eq.push_back(e);
          total = 0; n = 0;
        end
      end
    end
    idx = 0; cycles = 0; hold_pend = 1'b0;
    h_sum = '0; h_words = '0; h_sat = 1'b0;
    in_valid = 1'b0;
    while ((idx < wq.size() || eq.size() > 0) && cycles < 40000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && idx < wq.size() && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_data = wq[idx].d; in_last = wq[idx].l;
      end
      #1;
      if (hold_pend) begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== h_sum || out_words !== h_words || out_sat !== h_sat) begin
          errors++; $display("FAIL rnd_hold got v=%0b sum=%0d words=%0d sat=%0b want 1 %0d %0d %0b",
                             out_valid, out_sum, out_words, out_sat, h_sum, h_words, h_sat);
        end
      end
      checks++;
      if (in_ready4 !== in_ready) begin errors++; $display("FAIL rnd_rdy_pair got %0b want %0b", in_ready4, in_ready); end
      if (out_valid && out_ready) begin
        checks++;
        if (eq.size() == 0) begin
          errors++; $display("FAIL rnd_extra got sum=%0d want no result", out_sum);
        end else begin
          e = eq.pop_front();
          if (out_sum !== 16'(e.sum) || out_words !== 8'(e.words) || out_sat !== e.sat ||
              out_sum4 !== 4'(e.sum4) || out_sat4 !== e.sat4) begin
            errors++; $display("FAIL rnd_result got %0d/%0d/%0b w4 %0d/%0b want %0d/%0d/%0b w4 %0d/%0b",
                               out_sum, out_words, out_sat, out_sum4, out_sat4,
                               e.sum, e.words, e.sat, e.sum4, e.sat4);
          end
        end
      end
      hold_pend = out_valid && !out_ready;
      h_sum = out_sum; h_words = out_words; h_sat = out_sat;
      in_acc = in_valid && in_ready;
      tick();
      if (in_acc) begin
        idx++;
        in_valid = 1'b0;
      end
      cycles++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != wq.size() || eq.size() != 0) begin
      errors++; $display("FAIL rnd_complete sent %0d of %0d, %0d results outstanding want 0", idx, wq.size(), eq.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame3();
    test_single();
    test_back_to_back();
    test_sat();
    test_reset_midframe();
    test_throughput();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
